stat_resp_misr: RTL and testbench

STAT_RESP_MISR -- requirements
Module: stat_resp_misr

---
 rtl/stat_resp_misr.sv | 94 +++++++++
 tb/tb_stat_resp_misr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stat_resp_misr.sv
// Multiple-input signature register that compacts a counted run of response vectors.
// Optional build macro STAT_MISR_XMASK_EN adds resp_mask to zero out unknown response bits.
module stat_resp_misr #(
  parameter int               WIDTH = 32,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] seed,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef STAT_MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pat_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] num_q;
  logic [WIDTH-1:0] data_eff;
  logic             accept;
  logic             last_accept;

`ifdef STAT_MISR_XMASK_EN
  assign data_eff = resp_data & ~resp_mask;
`else
  assign data_eff = resp_data;
`endif

  // Handshake: a response transfers on any rising edge where resp_valid and
  // resp_ready are both high; resp_ready depends on the state alone.
  assign resp_ready  = (state_q == RUN);
  assign accept      = resp_ready && resp_valid;
  assign last_accept = accept && (cnt_q == (num_q - CNT_ONE));

  assign sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_eff;
  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_q   <= seed;
            cnt_q   <= '0;
            num_q   <= num_patterns;
            state_q <= (num_patterns == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here so a run cannot be disturbed.
          if (accept) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (last_accept) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign pat_count = cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stat_resp_misr.sv
// Directed bench for stat_resp_misr: scoreboarded final signatures plus
// reset, handshake, hold and latching checks.
module tb_stat_resp_misr;

  localparam int               WIDTH = 32;
  localparam int               CNT_W = 16;
  localparam logic [WIDTH-1:0] POLY  = 32'h04C11DB7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_patterns = '0;
  logic [WIDTH-1:0] seed = '0;
  logic             resp_valid = 1'b0;
  logic [WIDTH-1:0] resp_data = '0;
  logic             resp_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] pat_count;
  logic [1:0]       state_o;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model_sig;
  logic [CNT_W-1:0] model_cnt;
  logic [CNT_W-1:0] cur_num;
  logic [WIDTH-1:0] held_sig;

  stat_resp_misr #(.WIDTH(WIDTH), .CNT_W(CNT_W), .POLY(POLY)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_patterns(num_patterns),
    .seed(seed),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_ready(resp_ready),
    .busy(busy),
    .done(done),
    .signature(signature),
    .pat_count(pat_count),
    .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs sampled there too.
  task automatic start_run(input logic [WIDTH-1:0] s, input logic [CNT_W-1:0] n);
    @(negedge clk);
    start = 1'b1;
    seed = s;
    num_patterns = n;
    model_sig = s;
    model_cnt = '0;
    cur_num = n;
    @(negedge clk);
    start = 1'b0;
    seed = $urandom;
    num_patterns = CNT_W'($urandom_range(1, 9));
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    chk("ready_in_run", {31'b0, resp_ready}, 32'd1);
    resp_valid = 1'b1;
    resp_data = d;
    model_sig = misr_step(model_sig, d);
    model_cnt = model_cnt + 1'b1;
    if (model_cnt == cur_num) exp_q.push_back(model_sig);
    @(negedge clk);
    resp_valid = 1'b0;
    resp_data = $urandom;
  endtask

  task automatic check_done(input string tag);
    logic [WIDTH-1:0] exp_sig;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'b0, resp_ready}, 32'd0);
    chk({tag, "_cnt"}, {16'b0, pat_count}, {16'b0, model_cnt});
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_sig = exp_q.pop_front();
      chk({tag, "_sig"}, signature, exp_sig);
    end
  endtask

  initial begin
    // Reset state while rst_n is low
    #3;
    chk("rst_sig", signature, 32'h0);
    chk("rst_cnt", {16'b0, pat_count}, 32'h0);
    chk("rst_flags", {29'b0, busy, done, resp_ready}, 32'h0);
    chk("rst_state", {30'b0, state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // resp_valid in IDLE is dropped
    resp_valid = 1'b1;
    resp_data = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    chk("idle_drop_sig", signature, 32'h0);
    chk("idle_drop_cnt", {16'b0, pat_count}, 32'h0);
    chk("idle_state", {30'b0, state_o}, 32'd0);

    // Single response, seed 0
    start_run(32'h0, 16'd1);
    chk("r030_busy", {31'b0, busy}, 32'd1);
    chk("r030_state", {30'b0, state_o}, 32'd1);
    chk("r030_cnt0", {16'b0, pat_count}, 32'h0);
    send(32'h00000001);
    check_done("r030");
    chk("r030_const", signature, 32'h00000001);
    chk("r030_dstate", {30'b0, state_o}, 32'd2);

    // MSB feedback applies the polynomial
    start_run(32'h80000000, 16'd1);
    send(32'h0);
    check_done("r031");
    chk("r031_const", signature, 32'h04C11DB7);

    // Two back-to-back accepts
    start_run(32'h0, 16'd2);
    send(32'h1);
    chk("r032_mid_done", {31'b0, done}, 32'd0);
    send(32'h0);
    check_done("r032");
    chk("r032_const", signature, 32'h00000002);

    // DONE holds while resp_valid toggles
    held_sig = signature;
    resp_valid = 1'b1;
    repeat (3) begin
      resp_data = $urandom;
      @(negedge clk);
    end
    resp_valid = 1'b0;
    chk("hold_sig", signature, held_sig);
    chk("hold_cnt", {16'b0, pat_count}, 32'd2);
    chk("hold_done", {31'b0, done}, 32'd1);

    // Zero-length run goes straight to DONE
    start_run(32'hDEADBEEF, 16'd0);
    chk("r033_done", {31'b0, done}, 32'd1);
    chk("r033_sig", signature, 32'hDEADBEEF);
    chk("r033_cnt", {16'b0, pat_count}, 32'h0);
    chk("r033_ready", {31'b0, resp_ready}, 32'd0);
    @(negedge clk);
    chk("r033_ready2", {31'b0, resp_ready}, 32'd0);

    // start during RUN is ignored; inputs changed after start do not matter
    start_run(32'h12345678, 16'd3);
    start = 1'b1;
    seed = 32'hFFFF0000;
    num_patterns = 16'd1;
    send(32'hCAFEF00D);
    start = 1'b0;
    chk("ign_cnt", {16'b0, pat_count}, 32'd1);
    chk("ign_busy", {31'b0, busy}, 32'd1);
    send(32'h0BADF00D);
    send(32'h13579BDF);
    check_done("ign");

    // Longer random run with idle gaps between responses
    start_run($urandom, 16'd20);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        resp_data = $urandom;
        @(negedge clk);
        chk("gap_cnt", {16'b0, pat_count}, {16'b0, model_cnt});
      end
      send($urandom);
    end
    check_done("rand");

    // Asynchronous reset in the middle of a run
    start_run($urandom, 16'd4);
    send($urandom);
    send($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r034_async_sig", signature, 32'h0);
    chk("r034_async_cnt", {16'b0, pat_count}, 32'h0);
    chk("r034_async_flags", {29'b0, busy, done, resp_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r034_idle", {30'b0, state_o}, 32'd0);
    start_run(32'd5, 16'd4);
    chk("r034_restart_sig", signature, 32'd5);
    chk("r034_restart_cnt", {16'b0, pat_count}, 32'd0);
    for (int i = 0; i < 4; i++) send($urandom);
    check_done("r034");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
